// File: rtl/mod12_wrap_monitor.sv
// Watches a mod-12 up/down counter, queues wrap/load/illegal events in a small
// FIFO and keeps a net wrap count plus sticky illegal/overflow flags.
module mod12_wrap_monitor #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] count_in,
   input  logic       load,
   input  logic       clr,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic [5:0] evt_data,
   output logic [7:0] wrap_count,
   output logic       illegal,
   output logic       overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      CODE_WRAP_UP = 2'b00,
      CODE_WRAP_DN = 2'b01,
      CODE_LOAD    = 2'b10,
      CODE_ILLEGAL = 2'b11
   } evt_code_e;

   logic [3:0]       prev_reg;
   logic             load_q_reg;
   logic             prev_valid_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [CNT_W-1:0] occ_reg;
   logic [CNT_W-1:0] occ_next;
   logic [5:0]       mem_reg [FIFO_DEPTH];
   logic [7:0]       wrap_count_reg;
   logic [7:0]       wrap_count_next;
   logic             illegal_reg;
   logic             illegal_next;
   logic             overflow_reg;
   logic             overflow_next;

   logic             evt_hit;
   evt_code_e        evt_code;
   logic [5:0]       evt_word;
   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;
   logic             push;
   logic             drop;
   logic             is_out_of_range;
   logic [FIFO_DEPTH-1:0] wr_en;

   assign is_out_of_range = (count_in > 4'd11);

   // Priority classification of the transition prev -> count_in.
   always_comb begin
      evt_hit  = 1'b0;
      evt_code = CODE_WRAP_UP;
      if (prev_valid_reg) begin
         if (is_out_of_range) begin
            evt_hit  = 1'b1;
            evt_code = CODE_ILLEGAL;
         end else if (load_q_reg) begin
            evt_hit  = 1'b1;
            evt_code = CODE_LOAD;
         end else if (prev_reg == 4'd11 && count_in == 4'd0) begin
            evt_hit  = 1'b1;
            evt_code = CODE_WRAP_UP;
         end else if (prev_reg == 4'd0 && count_in == 4'd11) begin
            evt_hit  = 1'b1;
            evt_code = CODE_WRAP_DN;
         end
      end
   end

   assign evt_word   = {evt_code, count_in};
   assign fifo_empty = (occ_reg == '0);
   assign fifo_full  = (occ_reg == CNT_W'(FIFO_DEPTH));
   assign pop        = !fifo_empty && evt_ready;
   // A full FIFO can still take the event when the head leaves on the same edge.
   assign push       = evt_hit && (!fifo_full || pop);
   assign drop       = evt_hit && fifo_full && !pop;

   always_comb begin
      occ_next = occ_reg + CNT_W'(push) - CNT_W'(pop);
   end

   // Sets and counts are applied after clr so they win on a coincident edge.
   always_comb begin
      wrap_count_next = clr ? 8'd0 : wrap_count_reg;
      if (evt_hit && evt_code == CODE_WRAP_UP) begin
         wrap_count_next = wrap_count_next + 8'd1;
      end else if (evt_hit && evt_code == CODE_WRAP_DN) begin
         wrap_count_next = wrap_count_next - 8'd1;
      end
      illegal_next  = (illegal_reg & ~clr) | is_out_of_range;
      overflow_next = (overflow_reg & ~clr) | drop;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev_reg       <= 4'd0;
         load_q_reg     <= 1'b0;
         prev_valid_reg <= 1'b0;
         rd_ptr_reg     <= '0;
         wr_ptr_reg     <= '0;
         occ_reg        <= '0;
         wrap_count_reg <= 8'd0;
         illegal_reg    <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         prev_reg       <= count_in;
         load_q_reg     <= load;
         prev_valid_reg <= 1'b1;
         rd_ptr_reg     <= rd_ptr_reg + PTR_W'(pop);
         wr_ptr_reg     <= wr_ptr_reg + PTR_W'(push);
         occ_reg        <= occ_next;
         wrap_count_reg <= wrap_count_next;
         illegal_reg    <= illegal_next;
         overflow_reg   <= overflow_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_reg[i] <= 6'd0;
         end
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wr_en[i]) begin
               mem_reg[i] <= evt_word;
            end
         end
      end
   end

   assign evt_valid  = !fifo_empty;
   assign evt_data   = fifo_empty ? 6'd0 : mem_reg[rd_ptr_reg];
   assign wrap_count = wrap_count_reg;
   assign illegal    = illegal_reg;
   assign overflow   = overflow_reg;

endmodule

// File: tb/tb_mod12_wrap_monitor.sv
// Directed bench for mod12_wrap_monitor: queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_mod12_wrap_monitor;

   localparam int FIFO_DEPTH = 4;

   logic       clock;
   logic       reset;
   logic [3:0] count_in;
   logic       load;
   logic       clr;
   logic       evt_ready;
   logic       evt_valid;
   logic [5:0] evt_data;
   logic [7:0] wrap_count;
   logic       illegal;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   mod12_wrap_monitor #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .count_in   (count_in),
      .load       (load),
      .clr        (clr),
      .evt_ready  (evt_ready),
      .evt_valid  (evt_valid),
      .evt_data   (evt_data),
      .wrap_count (wrap_count),
      .illegal    (illegal),
      .overflow   (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d (0x%0h) want %0d (0x%0h)", name, $time, act, act, exp, exp);
      end
   endtask

   // Reference model: event queue, net wrap counter and sticky flags.
   logic [5:0] mq[$];
   int         m_wrap;
   bit         m_ill;
   bit         m_ovf;
   bit         have_last;
   bit         last_load;
   int         last_cnt;
   int         m_c;
   bit         m_ev;
   bit         m_pop;
   logic [1:0] m_code;

   initial begin
      mq.delete();
      m_wrap = 0; m_ill = 0; m_ovf = 0; have_last = 0; last_load = 0; last_cnt = 0;
      forever begin
         @(posedge clock or negedge reset);
         if (!reset) begin
            mq.delete();
            m_wrap = 0; m_ill = 0; m_ovf = 0;
            have_last = 0; last_load = 0; last_cnt = 0;
         end else begin
            m_c    = int'(count_in);
            m_pop  = (mq.size() != 0) && evt_ready;
            m_ev   = 0;
            m_code = 2'b00;
            if (have_last) begin
               if (m_c > 11)                          begin m_ev = 1; m_code = 2'b11; end
               else if (last_load)                    begin m_ev = 1; m_code = 2'b10; end
               else if (last_cnt == 11 && m_c == 0)   begin m_ev = 1; m_code = 2'b00; end
               else if (last_cnt == 0 && m_c == 11)   begin m_ev = 1; m_code = 2'b01; end
            end
            if (clr) begin
               m_wrap = 0; m_ill = 0; m_ovf = 0;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_ev) begin
               if (mq.size() < FIFO_DEPTH) mq.push_back({m_code, count_in});
               else m_ovf = 1;
               if (m_code == 2'b00) m_wrap = (m_wrap + 1) % 256;
               if (m_code == 2'b01) m_wrap = (m_wrap + 255) % 256;
            end
            if (m_c > 11) m_ill = 1;
            last_cnt  = m_c;
            last_load = load;
            have_last = 1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clock);
         chk("cyc_evt_valid", int'(evt_valid), (mq.size() != 0) ? 1 : 0);
         chk("cyc_evt_data", int'(evt_data), (mq.size() != 0) ? int'(mq[0]) : 0);
         chk("cyc_wrap_count", int'(wrap_count), m_wrap);
         chk("cyc_illegal", int'(illegal), int'(m_ill));
         chk("cyc_overflow", int'(overflow), int'(m_ovf));
      end
   end

   task automatic drive(input logic [3:0] c, input logic ld, input logic rdy, input logic cl);
      count_in  = c;
      load      = ld;
      evt_ready = rdy;
      clr       = cl;
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b0; count_in = 4'd0; load = 1'b0; clr = 1'b0; evt_ready = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_evt_valid", int'(evt_valid), 0);
      chk("rst_evt_data", int'(evt_data), 0);
      chk("rst_wrap_count", int'(wrap_count), 0);
      chk("rst_illegal", int'(illegal), 0);
      chk("rst_overflow", int'(overflow), 0);
      reset = 1'b1;

      // Up wrap 10,11,0; first edge only primes.
      drive(4'd10, 0, 1, 0);
      chk("prime_no_event", int'(evt_valid), 0);
      drive(4'd11, 0, 1, 0);
      drive(4'd0, 0, 1, 0);
      chk("up_valid", int'(evt_valid), 1);
      chk("up_data", int'(evt_data), 6'h00);
      chk("up_wrap", int'(wrap_count), 1);
      drive(4'd0, 0, 1, 0);
      chk("up_popped", int'(evt_valid), 0);

      // Down wrap 1,0,11 after clearing, then 10.
      drive(4'd0, 0, 1, 1);
      chk("clr_wrap", int'(wrap_count), 0);
      drive(4'd1, 0, 0, 0);
      drive(4'd0, 0, 0, 0);
      drive(4'd11, 0, 0, 0);
      chk("dn_data", int'(evt_data), 6'h1B);
      chk("dn_wrap", int'(wrap_count), 255);
      drive(4'd10, 0, 1, 0);
      chk("dn_popped", int'(evt_valid), 0);

      // 255 + 1 wraps to 0.
      drive(4'd11, 0, 1, 0);
      drive(4'd0, 0, 0, 0);
      chk("wrap_255_to_0", int'(wrap_count), 0);
      drive(4'd0, 0, 1, 0);

      // Load at 11, then 0: LOAD event only.
      drive(4'd10, 0, 1, 0);
      drive(4'd11, 1, 1, 0);
      drive(4'd0, 0, 0, 0);
      chk("load_data", int'(evt_data), 6'h20);
      chk("load_wrap", int'(wrap_count), 0);
      drive(4'd0, 0, 1, 0);
      chk("load_single", int'(evt_valid), 0);

      // Illegal 12 then 0: only the illegal event.
      drive(4'd10, 0, 0, 0);
      drive(4'd11, 0, 0, 0);
      drive(4'd12, 0, 0, 0);
      drive(4'd0, 0, 0, 0);
      chk("ill_data", int'(evt_data), 6'h3C);
      chk("ill_flag", int'(illegal), 1);
      drive(4'd0, 0, 1, 0);
      chk("ill_single", int'(evt_valid), 0);
      chk("ill_sticky", int'(illegal), 1);
      drive(4'd0, 0, 1, 1);
      chk("ill_clr", int'(illegal), 0);

      // Five up wraps into a 4-deep FIFO with no consumer.
      for (int w = 0; w < 5; w++) begin
         for (int v = 1; v <= 11; v++) drive(4'(v), 0, 0, 0);
         drive(4'd0, 0, 0, 0);
      end
      chk("ovf_flag", int'(overflow), 1);
      chk("ovf_wrap", int'(wrap_count), 5);
      for (int p = 0; p < 4; p++) begin
         drive(4'd0, 0, 1, 0);
         chk("ovf_drain_valid", int'(evt_valid), (p < 3) ? 1 : 0);
      end
      drive(4'd0, 0, 1, 1);
      chk("ovf_clr", int'(overflow), 0);
      chk("ovf_clr_wrap", int'(wrap_count), 0);

      // Push into a full FIFO with a simultaneous pop is accepted.
      drive(4'd11, 0, 0, 0);
      drive(4'd0, 0, 0, 0);
      drive(4'd11, 0, 0, 0);
      drive(4'd0, 0, 0, 0);
      chk("full_valid", int'(evt_valid), 1);
      drive(4'd11, 0, 1, 0);
      chk("full_pop_push_no_ovf", int'(overflow), 0);
      chk("full_pop_head", int'(evt_data), 6'h00);
      chk("full_pop_wrap", int'(wrap_count), 255);
      for (int p = 0; p < 3; p++) drive(4'd11, 0, 1, 0);
      chk("full_last_entry", int'(evt_data), 6'h1B);
      drive(4'd11, 0, 1, 0);
      chk("full_drained", int'(evt_valid), 0);

      // Wrap and clr on the same edge: count is 0 + 1.
      drive(4'd0, 0, 1, 1);
      chk("clr_vs_wrap", int'(wrap_count), 1);
      drive(4'd0, 0, 1, 0);

      // Distinct events, FIFO order, illegal set beating clr.
      drive(4'd13, 0, 0, 1);
      chk("clr_vs_ill", int'(illegal), 1);
      chk("clr_vs_ill_wrap", int'(wrap_count), 0);
      drive(4'd5, 1, 0, 0);
      drive(4'd6, 0, 0, 0);
      drive(4'd7, 0, 0, 0);
      drive(4'd0, 0, 0, 0);
      drive(4'd11, 0, 0, 0);
      chk("order_head0", int'(evt_data), 6'h3D);
      drive(4'd11, 0, 1, 0);
      chk("order_head1", int'(evt_data), 6'h26);
      drive(4'd12, 0, 0, 0);
      chk("order_hold", int'(evt_data), 6'h26);

      // Asynchronous reset with three queued events.
      #2 reset = 1'b0;
      #1;
      chk("midrst_valid", int'(evt_valid), 0);
      chk("midrst_data", int'(evt_data), 0);
      chk("midrst_wrap", int'(wrap_count), 0);
      chk("midrst_illegal", int'(illegal), 0);
      @(negedge clock);
      reset = 1'b1;
      drive(4'd11, 0, 1, 0);
      chk("post_rst_prime", int'(evt_valid), 0);
      drive(4'd11, 0, 1, 0);
      chk("post_rst_hold", int'(evt_valid), 0);
      chk("post_rst_wrap", int'(wrap_count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod12_wrap_monitor.md
MOD12_WRAP_MONITOR -- requirements
Module: mod12_wrap_monitor

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving event FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have port clock, input, 1 bit: single clock; all state updates on posedge clock.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port count_in, input, 4 bits: mod-12 up/down counter output, sampled every posedge.
REQ-005 The block SHALL have port load, input, 1 bit: counter load strobe, sampled every posedge.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear of sticky flags and wrap_count.
REQ-007 The block SHALL have port evt_ready, input, 1 bit: consumer accepts the head event.
REQ-008 The block SHALL have port evt_valid, output, 1 bit: FIFO non-empty.
REQ-009 The block SHALL have port evt_data, output, 6 bits: head event {code[1:0], value[3:0]}.
REQ-010 The block SHALL have port wrap_count, output, 8 bits: net wrap count, modulo 256.
REQ-011 The block SHALL have port illegal, output, 1 bit: sticky; a value of 12..15 was sampled.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky; an event was dropped because the FIFO was full.

Function
REQ-013 Each posedge SHALL register cur=count_in into prev, load into load_q, and set prev_valid=1.
REQ-014 Classification at an edge SHALL compare the new count_in against prev and SHALL occur only when prev_valid=1; the first edge after reset produces no event.
REQ-015 Event codes SHALL be evaluated in priority order: 2'b11 ILLEGAL (count_in>11); 2'b10 LOAD (load_q=1); 2'b00 WRAP_UP (prev=11, count_in=0); 2'b01 WRAP_DN (prev=0, count_in=11). All other transitions, including holds and ±1 steps, produce no event.
REQ-016 At most one event SHALL be generated per edge, and value[3:0] SHALL equal the count_in sampled at that edge.
REQ-017 An event SHALL be written into the FIFO at the same edge that samples the transition, and evt_valid SHALL rise in the following cycle if the FIFO was empty (latency 1 from sample edge).
REQ-018 A pop SHALL occur at a posedge with evt_valid=1 and evt_ready=1; evt_data SHALL present the oldest entry (FIFO order) combinationally from storage.
REQ-019 A push into a full FIFO SHALL succeed if a pop occurs at the same edge; otherwise the event SHALL be dropped and overflow set.
REQ-020 A simultaneous push and pop on an empty FIFO SHALL NOT be allowed; a push only is performed, since evt_valid=0.
REQ-021 The FIFO SHALL track occupancy 0..FIFO_DEPTH, with wrap-around of the read and write pointers modulo FIFO_DEPTH.
REQ-022 wrap_count SHALL increment by 1 on a WRAP_UP event and decrement by 1 on a WRAP_DN event, wrapping modulo 256 (255+1=0, 0-1=255).
REQ-023 wrap_count SHALL be updated whether or not the event was dropped.
REQ-024 illegal SHALL be set on any edge sampling count_in>11, regardless of prev_valid.
REQ-025 clr SHALL zero illegal, overflow and wrap_count; a set or count condition at the same edge SHALL win over clr, with wrap_count taking the value 0±1.
REQ-026 clr SHALL NOT affect FIFO contents, prev, or prev_valid.
REQ-027 evt_valid and evt_data SHALL be stable while evt_valid=1 and evt_ready=0.

Reset
REQ-028 While reset=0, the block SHALL hold FIFO empty, evt_valid=0, evt_data=6'd0, wrap_count=0, illegal=0, overflow=0, prev=0, load_q=0, prev_valid=0, asynchronously.
REQ-029 Reset asserted mid-operation SHALL discard all queued events immediately.
REQ-030 After release of reset, the first posedge SHALL only prime prev.

Verification
REQ-031 Up wrap: drive count_in 10,11,0 with evt_ready=1 -> one event {00,0}; wrap_count=1.
REQ-032 Down wrap: drive count_in 1,0,11,10 -> one event {01,11}; wrap_count goes 0->255.
REQ-033 Load versus wrap: load=1 one cycle at count 11, then count_in=0 -> event {10,0} only; wrap_count unchanged.
REQ-034 Illegal value: drive count_in 11,12,0 -> events {11,12} then {00,0}? No: prev=12, so only {11,12}; illegal=1 until clr.
REQ-035 Overflow: evt_ready=0, generate 5 wraps with FIFO_DEPTH=4 -> 4 entries queued, overflow=1, wrap_count=5; then pop all in order with evt_ready=1 -> evt_valid falls after the 4th pop.
REQ-036 Reset mid-operation: assert reset with 3 queued events -> evt_valid=0 immediately; after release, a first sample of count_in=0 yields no event.
